// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Owns the single register-file write port. Pipeline writeback has priority;
//   long-latency unit (LLU) results are buffered in a small FIFO and drained on
//   idle write-port cycles. If writeback keeps the FIFO blocked for
//   STARVE_LIMIT cycles, wb_hold freezes writeback for one cycle so the FIFO
//   head gets through. A per-register scoreboard (busy) tracks LLU
//   destinations in flight so decode can stall on hazards.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   wb_wr/wb_addr/wb_din            writeback write request
//   wb_hold                         writeback must freeze this cycle
//   llu_issue/llu_issue_addr        LLU op issued, marks destination busy
//   llu_valid/llu_addr/llu_data     LLU result, pushed when llu_ready
//   llu_ready                       FIFO has room (registered count only)
//   chk_a/b/d_addr, stall           decode hazard check against busy
//   busy                            scoreboard vector
//   wr_reg/reg_addr/reg_din         register-file write port
//   proto_err                       sticky protocol violation
module reg_write_arbiter #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_REGS            = 16,
  parameter int FIFO_DEPTH          = 2,
  parameter int STARVE_LIMIT        = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_wr,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_addr,
  input  logic [DBITS-1:0]               wb_din,
  output logic                           wb_hold,
  input  logic                           llu_issue,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] llu_issue_addr,
  input  logic                           llu_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] llu_addr,
  input  logic [DBITS-1:0]               llu_data,
  output logic                           llu_ready,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] chk_a_addr,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] chk_b_addr,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] chk_d_addr,
  output logic                           stall,
  output logic [NUM_REGS-1:0]            busy,
  output logic                           wr_reg,
  output logic [REG_INDEX_BIT_WIDTH-1:0] reg_addr,
  output logic [DBITS-1:0]               reg_din,
  output logic                           proto_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [REG_INDEX_BIT_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DBITS-1:0]               r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]                  r_rd_ptr;
  logic [PW-1:0]                  r_wr_ptr;
  logic [CW-1:0]                  r_count;
  logic [SW-1:0]                  r_starve_left;
  logic                           r_wb_hold;
  logic                           r_proto_err;
  logic [NUM_REGS-1:0]            r_busy;

  logic                           w_fifo_nempty;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_wb_grant;
  logic                           w_err;
  logic [REG_INDEX_BIT_WIDTH-1:0] w_head_addr;
  logic [DBITS-1:0]               w_head_data;
  logic [NUM_REGS-1:0]            w_set_mask;
  logic [NUM_REGS-1:0]            w_clr_mask;

  assign w_fifo_nempty = (r_count != '0);
  assign llu_ready     = (r_count < CW'(FIFO_DEPTH));
  assign w_push        = llu_valid & llu_ready;
  assign w_head_addr   = r_fifo_addr[r_rd_ptr];
  assign w_head_data   = r_fifo_data[r_rd_ptr];

  // Write-port grant; everything is held idle while reset is asserted.
  always_comb begin
    w_pop      = 1'b0;
    w_wb_grant = 1'b0;
    if (!reset) begin
      if (r_wb_hold && w_fifo_nempty) w_pop = 1'b1;
      else if (wb_wr)                 w_wb_grant = 1'b1;
      else if (w_fifo_nempty)         w_pop = 1'b1;
    end
  end

  always_comb begin
    wr_reg   = w_pop | w_wb_grant;
    reg_addr = '0;
    reg_din  = '0;
    if (w_pop) begin
      reg_addr = w_head_addr;
      reg_din  = w_head_data;
    end else if (w_wb_grant) begin
      reg_addr = wb_addr;
      reg_din  = wb_din;
    end
  end

  assign w_set_mask = llu_issue ? (NUM_REGS'(1) << llu_issue_addr) : '0;
  assign w_clr_mask = w_pop     ? (NUM_REGS'(1) << w_head_addr)    : '0;

  // Re-issuing to a register whose result drains this very cycle is legal.
  assign w_err = (llu_valid & ~llu_ready)
               | (llu_issue & r_busy[llu_issue_addr] & ~w_clr_mask[llu_issue_addr])
               | (w_wb_grant & r_busy[wb_addr])
               | (llu_valid & ~r_busy[llu_addr]);

  // Result storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo_addr[r_wr_ptr] <= llu_addr;
      r_fifo_data[r_wr_ptr] <= llu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_starve_left <= SW'(STARVE_LIMIT);
      r_wb_hold     <= 1'b0;
      r_proto_err   <= 1'b0;
      r_busy        <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      // Down-counter of remaining blocked cycles; terminal count raises hold.
      r_wb_hold <= 1'b0;
      if (w_pop || !w_fifo_nempty) begin
        r_starve_left <= SW'(STARVE_LIMIT);
      end else if (wb_wr) begin
        if (r_starve_left == SW'(1)) begin
          r_wb_hold     <= 1'b1;
          r_starve_left <= SW'(STARVE_LIMIT);
        end else begin
          r_starve_left <= r_starve_left - SW'(1);
        end
      end

      // Set after clear so a same-cycle issue wins.
      r_busy      <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_proto_err <= r_proto_err | w_err;
    end
  end

  assign wb_hold   = r_wb_hold;
  assign busy      = r_busy;
  assign proto_err = r_proto_err;
  assign stall     = r_busy[chk_a_addr] | r_busy[chk_b_addr] | r_busy[chk_d_addr];

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int FD = 2;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_wr;
  logic [3:0]  wb_addr;
  logic [31:0] wb_din;
  logic        wb_hold;
  logic        llu_issue;
  logic [3:0]  llu_issue_addr;
  logic        llu_valid;
  logic [3:0]  llu_addr;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic [3:0]  chk_a_addr, chk_b_addr, chk_d_addr;
  logic        stall;
  logic [15:0] busy;
  logic        wr_reg;
  logic [3:0]  reg_addr;
  logic [31:0] reg_din;
  logic        proto_err;

  reg_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_din(wb_din), .wb_hold(wb_hold),
    .llu_issue(llu_issue), .llu_issue_addr(llu_issue_addr),
    .llu_valid(llu_valid), .llu_addr(llu_addr), .llu_data(llu_data),
    .llu_ready(llu_ready),
    .chk_a_addr(chk_a_addr), .chk_b_addr(chk_b_addr), .chk_d_addr(chk_d_addr),
    .stall(stall), .busy(busy),
    .wr_reg(wr_reg), .reg_addr(reg_addr), .reg_din(reg_din),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: result queue, busy bits, sticky error, blocked-cycle count.
  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_busy = '0;
  logic        m_err = 1'b0;
  int          m_starve = 0;
  logic        m_hold = 1'b0;

  logic        e_pop, e_wbg, e_wr, e_ready, e_stall;
  logic [3:0]  e_addr;
  logic [31:0] e_din;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] pending[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    e_ready = (m_q.size() < FD);
    e_pop = 1'b0; e_wbg = 1'b0; e_wr = 1'b0; e_addr = '0; e_din = '0;
    if (m_hold && m_q.size() > 0) e_pop = 1'b1;
    else if (wb_wr)               e_wbg = 1'b1;
    else if (m_q.size() > 0)      e_pop = 1'b1;
    if (e_pop) begin
      e_wr = 1'b1; e_addr = m_q[0].a; e_din = m_q[0].d;
    end else if (e_wbg) begin
      e_wr = 1'b1; e_addr = wb_addr; e_din = wb_din;
    end
    e_stall = m_busy[chk_a_addr] | m_busy[chk_b_addr] | m_busy[chk_d_addr];
  endtask

  task automatic model_update();
    logic ready_pre;
    ent_t e;
    model_eval();
    if (reset) begin
      m_q.delete(); m_busy = '0; m_err = 1'b0; m_starve = 0; m_hold = 1'b0;
    end else begin
      ready_pre = (m_q.size() < FD);
      if (llu_valid && !ready_pre) m_err = 1'b1;
      if (llu_issue && m_busy[llu_issue_addr] && !(e_pop && m_q[0].a == llu_issue_addr))
        m_err = 1'b1;
      if (e_wbg && m_busy[wb_addr]) m_err = 1'b1;
      if (llu_valid && !m_busy[llu_addr]) m_err = 1'b1;
      if (e_pop) m_busy[m_q[0].a] = 1'b0;
      if (llu_issue) m_busy[llu_issue_addr] = 1'b1;
      if (m_q.size() == 0 || e_pop) begin
        m_starve = 0; m_hold = 1'b0;
      end else if (wb_wr) begin
        m_starve++;
        m_hold = (m_starve == SL);
        if (m_starve == SL) m_starve = 0;
      end else begin
        m_hold = 1'b0;
      end
      if (e_pop) void'(m_q.pop_front());
      if (llu_valid && ready_pre) begin
        e.a = llu_addr; e.d = llu_data;
        m_q.push_back(e);
      end
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    if (reset) begin
      chk({tag, ".wr_reg_in_reset"}, 64'(wr_reg), 64'(1'b0));
    end else begin
      chk({tag, ".wr_reg"},    64'(wr_reg),    64'(e_wr));
      chk({tag, ".reg_addr"},  64'(reg_addr),  64'(e_addr));
      chk({tag, ".reg_din"},   64'(reg_din),   64'(e_din));
      chk({tag, ".llu_ready"}, 64'(llu_ready), 64'(e_ready));
      chk({tag, ".wb_hold"},   64'(wb_hold),   64'(m_hold));
      chk({tag, ".stall"},     64'(stall),     64'(e_stall));
      chk({tag, ".busy"},      64'(busy),      64'(m_busy));
      chk({tag, ".proto_err"}, 64'(proto_err), 64'(m_err));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic idle();
    reset = 1'b0; wb_wr = 1'b0; wb_addr = '0; wb_din = '0;
    llu_issue = 1'b0; llu_issue_addr = '0;
    llu_valid = 1'b0; llu_addr = '0; llu_data = '0;
  endtask

  initial begin
    idle();
    chk_a_addr = '0; chk_b_addr = '0; chk_d_addr = '0;

    // Reset with traffic present
    reset = 1'b1; wb_wr = 1'b1; wb_addr = 4'd2; wb_din = 32'h1234; llu_valid = 1'b1; llu_addr = 4'd6;
    step("reset0");
    step("reset1");
    idle();
    sample("post_reset");
    chk("post_reset.llu_ready", 64'(llu_ready), 64'(1'b1));
    chk("post_reset.busy", 64'(busy), 64'(0));
    chk("post_reset.proto_err", 64'(proto_err), 64'(1'b0));
    advance();

    // Single LLU result
    llu_issue = 1'b1; llu_issue_addr = 4'd5;
    step("issue5");
    idle(); llu_valid = 1'b1; llu_addr = 4'd5; llu_data = 32'hDEADBEEF; chk_a_addr = 4'd5;
    sample("result5");
    chk("result5.busy5", 64'(busy[5]), 64'(1'b1));
    chk("result5.stall", 64'(stall), 64'(1'b1));
    advance();
    idle();
    sample("drain5");
    chk("drain5.wr_reg", 64'(wr_reg), 64'(1'b1));
    chk("drain5.reg_addr", 64'(reg_addr), 64'(5));
    chk("drain5.reg_din", 64'(reg_din), 64'(32'hDEADBEEF));
    advance();
    sample("after5");
    chk("after5.busy5", 64'(busy[5]), 64'(1'b0));
    advance();
    chk_a_addr = '0;

    // Writeback priority
    llu_issue = 1'b1; llu_issue_addr = 4'd3;
    step("issue3");
    idle(); llu_valid = 1'b1; llu_addr = 4'd3; llu_data = 32'h33;
    step("result3");
    idle(); wb_wr = 1'b1; wb_addr = 4'd7; wb_din = 32'h77;
    for (int i = 0; i < 3; i++) begin
      sample("wb7");
      chk("wb7.reg_addr", 64'(reg_addr), 64'(7));
      advance();
    end
    idle();
    sample("drain3");
    chk("drain3.reg_addr", 64'(reg_addr), 64'(3));
    advance();

    // Starvation hold
    llu_issue = 1'b1; llu_issue_addr = 4'd9;
    step("issue9");
    idle(); llu_valid = 1'b1; llu_addr = 4'd9; llu_data = 32'h99;
    step("result9");
    idle(); wb_wr = 1'b1; wb_addr = 4'd10; wb_din = 32'hA0;
    for (int i = 0; i < 11; i++) begin
      sample("starve");
      chk("starve.wb_hold", 64'(wb_hold), 64'(i == SL));
      if (i == SL) chk("starve.reg_addr", 64'(reg_addr), 64'(9));
      advance();
    end
    idle();
    step("starve_done");

    // Full FIFO
    llu_issue = 1'b1; llu_issue_addr = 4'd1;
    step("issue1");
    llu_issue_addr = 4'd2;
    step("issue2");
    idle(); wb_wr = 1'b1; wb_addr = 4'd11; wb_din = 32'hB0;
    llu_valid = 1'b1; llu_addr = 4'd1; llu_data = 32'h1111;
    step("push1");
    llu_addr = 4'd2; llu_data = 32'h2222;
    step("push2");
    llu_addr = 4'd1; llu_data = 32'h3333;
    sample("push_full");
    chk("full.llu_ready", 64'(llu_ready), 64'(1'b0));
    advance();
    idle();
    sample("drain1");
    chk("full.proto_err", 64'(proto_err), 64'(1'b1));
    chk("drain1.reg_addr", 64'(reg_addr), 64'(1));
    chk("drain1.reg_din", 64'(reg_din), 64'(32'h1111));
    advance();
    sample("drain2");
    chk("drain2.reg_addr", 64'(reg_addr), 64'(2));
    chk("drain2.reg_din", 64'(reg_din), 64'(32'h2222));
    advance();
    step("full_done");

    // Set-wins and sticky error
    reset = 1'b1;
    step("reset_mid");
    idle(); llu_issue = 1'b1; llu_issue_addr = 4'd4;
    step("issue4");
    idle(); llu_valid = 1'b1; llu_addr = 4'd4; llu_data = 32'h4444;
    step("result4");
    idle(); llu_issue = 1'b1; llu_issue_addr = 4'd4;
    sample("drain4_reissue");
    chk("drain4.reg_addr", 64'(reg_addr), 64'(4));
    advance();
    sample("setwins");
    chk("setwins.busy4", 64'(busy[4]), 64'(1'b1));
    chk("setwins.proto_err", 64'(proto_err), 64'(1'b0));
    advance();
    idle();
    sample("reissue_err");
    chk("reissue.proto_err", 64'(proto_err), 64'(1'b1));
    advance();
    step("sticky1");
    sample("sticky2");
    chk("sticky.proto_err", 64'(proto_err), 64'(1'b1));
    advance();

    // Randomized traffic
    reset = 1'b1;
    step("rand_reset");
    pending.delete();
    for (int n = 0; n < 400; n++) begin
      logic use_pend;
      reset = ($urandom_range(0, 99) < 2);
      llu_issue = ($urandom_range(0, 3) == 0);
      llu_issue_addr = 4'($urandom_range(0, 15));
      wb_wr = ($urandom_range(0, 9) < 6);
      wb_addr = 4'($urandom_range(0, 15));
      wb_din = $urandom;
      llu_valid = ($urandom_range(0, 9) < 4);
      use_pend = (pending.size() > 0) && ($urandom_range(0, 9) != 0);
      llu_addr = use_pend ? pending[0] : 4'($urandom_range(0, 15));
      llu_data = $urandom;
      chk_a_addr = 4'($urandom_range(0, 15));
      chk_b_addr = 4'($urandom_range(0, 15));
      chk_d_addr = 4'($urandom_range(0, 15));
      if (reset) begin
        pending.delete();
      end else begin
        if (llu_valid && use_pend && m_q.size() < FD) void'(pending.pop_front());
        if (llu_issue) pending.push_back(llu_issue_addr);
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Owns the single register-file write port and shares it between the pipeline writeback stage and the long-latency unit (LLU: multiplier/divider, slow I/O loads). Pipeline writeback has priority. LLU results are buffered in a small FIFO and drained on idle write-port cycles. A per-register scoreboard tracks LLU destinations in flight, so decode can stall on RAW/WAW hazards. It sits between the writeback stage and the register file, replacing the direct wr_reg/reg_addr/reg_din connection.

## Interface
- DBITS, 32, data width
- REG_INDEX_BIT_WIDTH, 4, register index width
- NUM_REGS, 16, scoreboard entries (2^REG_INDEX_BIT_WIDTH)
- FIFO_DEPTH, 2, LLU result buffer entries
- STARVE_LIMIT, 8, consecutive blocked cycles before writeback is held

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wb_wr  in  1  writeback stage requests a register write
- wb_addr  in  REG_INDEX_BIT_WIDTH  writeback destination
- wb_din  in  DBITS  writeback data
- wb_hold  out  1  pipeline must freeze MEM/WB this cycle; its write is not taken
- llu_issue  in  1  LLU accepted an op that will write llu_issue_addr
- llu_issue_addr  in  REG_INDEX_BIT_WIDTH  destination of issued LLU op
- llu_valid  in  1  LLU result available
- llu_addr  in  REG_INDEX_BIT_WIDTH  result destination
- llu_data  in  DBITS  result data
- llu_ready  out  1  FIFO can accept a result this cycle
- chk_a_addr, chk_b_addr, chk_d_addr  in  REG_INDEX_BIT_WIDTH each  decode source A, source B and destination
- stall  out  1  busy[chk_a] | busy[chk_b] | busy[chk_d]
- busy  out  NUM_REGS  scoreboard vector
- wr_reg  out  1  register-file write enable
- reg_addr  out  REG_INDEX_BIT_WIDTH  register-file write address
- reg_din  out  DBITS  register-file write data
- proto_err  out  1  sticky protocol violation flag

## Operation
- **FIFO:** circular, FIFO_DEPTH entries of {addr, data}, with a count register.
  - llu_ready = (count < FIFO_DEPTH), computed from registered count only.
  - Push on llu_valid & llu_ready.
  - A push to a full FIFO is dropped and sets proto_err.
- **Write-port grant** (combinational, each cycle):
  - If wb_hold & fifo nonempty: FIFO head is written and popped; the writeback request is ignored.
  - Else if wb_wr: writeback is written.
  - Else if fifo nonempty: FIFO head is written and popped.
  - Else wr_reg=0, reg_addr=0, reg_din=0.
- **Starvation counter** (0..STARVE_LIMIT):
  - Increments on cycles with wb_wr=1, fifo nonempty and no FIFO pop.
  - Clears on any FIFO pop or an empty FIFO.
  - wb_hold is a register, set for exactly one cycle on the edge where the counter reaches STARVE_LIMIT. The counter then clears.
- **Scoreboard:**
  - busy[llu_issue_addr] sets on llu_issue.
  - busy[reg_addr] clears when a FIFO entry is written to the register file.
  - If set and clear hit the same register in the same cycle, set wins.
- **proto_err** (sticky until reset) also sets on:
  - llu_issue to an already-busy register;
  - wb_wr (granted) to a busy register;
  - llu_valid to a non-busy register.
- **Reset:** FIFO empty, count=0, busy=0, counter=0, wb_hold=0, proto_err=0. wr_reg is forced to 0 while reset=1.

## Timing
- Writeback: zero latency; wb_* to wr_reg/reg_addr/reg_din is combinational in the same cycle.
- LLU result: minimum 1 cycle. A result pushed at edge N can be written in cycle N+1 if wb_wr=0.
- Simultaneous push and pop: allowed when count < FIFO_DEPTH. count is unchanged and pointers wrap modulo FIFO_DEPTH.
- A pop at count=1 with a push in the same cycle: the new entry is the head next cycle, with no bubble.
- busy updates at the edge after issue/drain; stall reflects registered busy, with no bypass of same-cycle llu_issue.
- Worst-case LLU result wait under continuous writeback is STARVE_LIMIT+1 cycles.
- Reset mid-operation discards buffered results and clears busy. The next cycle after reset deasserts is idle.

## Test plan
- **Reset:** reset=1 for 2 cycles with wb_wr=1 and llu_valid=1 -> wr_reg=0, llu_ready=1, busy=0, proto_err=0 after release.
- **Single LLU result:** issue to r5, then result 0xDEADBEEF for r5 with wb_wr=0 -> busy[5]=1 and stall=1 with chk_a=5; next cycle wr_reg=1, reg_addr=5, reg_din=0xDEADBEEF; busy[5]=0 the following cycle.
- **Writeback priority:** FIFO holds r3, and wb_wr=1 to r7 for 3 cycles -> r7 written each cycle, r3 written on the 4th cycle after wb_wr drops.
- **Starvation hold:** FIFO nonempty and wb_wr=1 constantly -> wb_hold=1 for exactly one cycle after 8 blocked cycles; FIFO head written that cycle; counter restarts.
- **Full FIFO:** push results for r1 and r2 with wb_wr=1 -> llu_ready=0. A third llu_valid sets proto_err and r1/r2 are retained and drained in order.
- **Set-wins and error:** llu_issue r4 in the same cycle r4 drains from the FIFO -> busy[4]=1 and proto_err=0. A second llu_issue to r4 -> proto_err=1, sticky.
